// File: rtl/alu_pipe.sv
// Handshaked ALU for the accumulator datapath: single-cycle logic/arith/shift
// ops, an iterative shift-add multiply, and registered result flags.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             neg,
   output logic             illegal,
   output logic             acc_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULB = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      OP_PASS = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_LDB  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8,
      OP_SAR  = 4'd9,
      OP_MUL  = 4'd10
   } op_e;

   localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               neg_q, neg_d;
   logic               illegal_q, illegal_d;

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_step;

   logic               accept;
   logic               load_alu;
   logic               start_mul;
   logic               mul_done;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               alu_ill;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [2*WIDTH-1:0] shl_w;
   logic [2*WIDTH-1:0] shr_w;
   logic [2*WIDTH-1:0] sar_w;
   logic [SHW-1:0]     shamt;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == ST_HOLD);
   assign acc_zero  = (a == '0);
   assign shamt     = b[SHW-1:0];

   // Shifts run in a double-width field so the last bit shifted out lands at
   // a fixed position, whatever the amount.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
      sum_w   = {1'b0, a} + {1'b0, b};
      diff_w  = {1'b0, a} - {1'b0, b};
      shl_w   = {{WIDTH{1'b0}}, a} << shamt;
      shr_w   = {a, {WIDTH{1'b0}}} >> shamt;
      sar_w   = $unsigned($signed({a, {WIDTH{1'b0}}}) >>> shamt);
      alu_res = a;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (op)
         OP_PASS: ;
         OP_ADD: begin
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_w[WIDTH-1:0];
            alu_c   = diff_w[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_LDB:  alu_res = b;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[2*WIDTH-1:WIDTH];
            alu_c   = shr_w[WIDTH-1];
         end
         OP_SAR: begin
            alu_res = sar_w[2*WIDTH-1:WIDTH];
            alu_c   = sar_w[WIDTH-1];
         end
         OP_MUL:  ;
         default: alu_ill = 1'b1;
      endcase
   end

   assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

   always_comb begin
      state_d   = state_q;
      load_alu  = 1'b0;
      start_mul = 1'b0;
      mul_done  = 1'b0;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  start_mul = 1'b1;
                  state_d   = ST_MULB;
               end else begin
                  load_alu  = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else if ((state_q == ST_HOLD) && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_MULB: begin
            if (cnt_q == LAST_ITER) begin
               mul_done = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      if (start_mul) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         prod_d   = '0;
         cnt_d    = '0;
      end else if (state_q == ST_MULB) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         prod_d   = prod_step;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   // Flags change only when a result is loaded; otherwise they hold.
   always_comb begin
      result_d  = result_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      neg_d     = neg_q;
      illegal_d = illegal_q;
      if (load_alu) begin
         result_d  = alu_res;
         carry_d   = alu_c;
         ovf_d     = alu_v;
         illegal_d = alu_ill;
      end else if (mul_done) begin
         result_d  = prod_step[WIDTH-1:0];
         carry_d   = |prod_step[2*WIDTH-1:WIDTH];
         ovf_d     = 1'b0;
         illegal_d = 1'b0;
      end
      if (load_alu || mul_done) begin
         zero_d = (result_d == '0);
         neg_d  = result_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      // NOTE: the multiplier partials are reset too, so an aborted multiply can never leak into a later result.
      if (!rst_) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         neg_q     <= 1'b0;
         illegal_q <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         neg_q     <= neg_d;
         illegal_q <= illegal_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         prod_q    <= prod_d;
         cnt_q     <= cnt_d;
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign carry   = carry_q;
   assign ovf     = ovf_q;
   assign neg     = neg_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expectations are queued at accept and
// compared, along with output latency, when each result transfers.
module tb_alu_pipe;

   localparam int W   = 8;
   localparam int SHW = 3;

   logic         clk = 1'b0;
   logic         rst_;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero, carry, ovf, neg, illegal, acc_zero;

   bit           rnd_bp;
   int           total = 0;
   int           bad   = 0;
   int           cyc   = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         n;
      logic         ill;
      int           due;
   } exp_t;

   exp_t sb[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_     (rst_),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zero     (zero),
      .carry    (carry),
      .ovf      (ovf),
      .neg      (neg),
      .illegal  (illegal),
      .acc_zero (acc_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: shifts are done one bit at a time, multiply natively.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t         e;
      logic [W:0]   wide;
      logic [2*W-1:0] p;
      logic [W-1:0] t;
      int           sh;
      e.res = x; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.due = 0;
      sh = int'(y[SHW-1:0]);
      t  = x;
      case (o)
         4'd0: e.res = x;
         4'd1: begin
            wide  = {1'b0, x} + {1'b0, y};
            e.res = wide[W-1:0];
            e.c   = wide[W];
            e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         4'd2: begin
            e.res = x - y;
            e.c   = (x < y);
            e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         4'd3: e.res = x & y;
         4'd4: e.res = x | y;
         4'd5: e.res = x ^ y;
         4'd6: e.res = y;
         4'd7: begin
            for (int i = 0; i < sh; i++) begin e.c = t[W-1]; t = {t[W-2:0], 1'b0}; end
            e.res = t;
         end
         4'd8: begin
            for (int i = 0; i < sh; i++) begin e.c = t[0]; t = {1'b0, t[W-1:1]}; end
            e.res = t;
         end
         4'd9: begin
            for (int i = 0; i < sh; i++) begin e.c = t[0]; t = {t[W-1], t[W-1:1]}; end
            e.res = t;
         end
         4'd10: begin
            p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            e.res = p[W-1:0];
            e.c   = |p[2*W-1:W];
         end
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == '0);
      e.n = e.res[W-1];
      return e;
   endfunction

   // Monitor: samples mid-low-phase, when inputs driven at negedge are settled.
   initial begin : monitor
      bit   pv;
      bit   pt;
      exp_t e;
      pv = 1'b0;
      pt = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         #2;
         if (!rst_) begin
            pv = 1'b0;
            pt = 1'b0;
         end else begin
            if (out_valid && (!pv || pt)) begin
               if (sb.size() == 0) check("spurious_valid", 1, 0);
               else check("latency", 64'(cyc), 64'(sb[0].due));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("result",  result,  e.res);
                  check("zero",    zero,    e.z);
                  check("carry",   carry,   e.c);
                  check("ovf",     ovf,     e.v);
                  check("neg",     neg,     e.n);
                  check("illegal", illegal, e.ill);
               end
            end
            if (in_valid && in_ready) begin
               e     = model(op, a, b);
               e.due = cyc + ((op == 4'd10) ? W + 1 : 1);
               sb.push_back(e);
            end
            pv = out_valid;
            pt = out_valid && out_ready;
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
         #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin : driver
      int n;
      rst_ = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
      out_ready = 1'b1; rnd_bp = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result",    result,    0);
      check("rst_flags",     {zero, carry, ovf, neg, illegal}, 0);
      check("acc_zero_0",    acc_zero,  1);
      a = 8'h5A;
      #1;
      check("acc_zero_5a",   acc_zero,  0);
      @(negedge clk);
      rst_ = 1'b1;
      #1;
      check("rst_in_ready",  in_ready,  1);

      issue(4'd1, 8'hFF, 8'h01);
      issue(4'd1, 8'h7F, 8'h01);
      issue(4'd2, 8'h00, 8'h01);
      issue(4'd2, 8'h80, 8'h01);
      issue(4'd10, 8'h10, 8'h11);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check("mul_in_ready", in_ready, 0);
         check("mul_busy_valid", out_valid, 0);
      end
      issue(4'd10, 8'h0F, 8'h0F);
      issue(4'd8, 8'h81, 8'h01);
      issue(4'd9, 8'h80, 8'h03);
      issue(4'd7, 8'h01, 8'h00);
      issue(4'd12, 8'h3C, 8'h55);
      issue(4'd0, 8'hA5, 8'h00);
      issue(4'd3, 8'hF0, 8'h3C);
      issue(4'd4, 8'hF0, 8'h0C);
      issue(4'd5, 8'hFF, 8'hFF);
      issue(4'd6, 8'h11, 8'h80);
      issue(4'd7, 8'hC1, 8'h07);
      idle(3);

      // Backpressure: result parked in HOLD while a new op waits.
      out_ready = 1'b0;
      issue(4'd1, 8'h11, 8'h22);
      @(negedge clk);
      in_valid = 1'b1; op = 4'd1; a = 8'h01; b = 8'h02;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_ready",  in_ready,  0);
         check("bp_out_valid", out_valid, 1);
         check("bp_result",    result,    8'h33);
         check("bp_flags",     {zero, carry, ovf, neg, illegal}, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("bp_next_valid",  out_valid, 1);
      check("bp_next_result", result,    8'h03);
      idle(3);

      // Asynchronous reset in the middle of a multiply.
      issue(4'd12, 8'h80, 8'h00);
      issue(4'd10, 8'h10, 8'h11);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_ = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_result",    result,    0);
      check("abort_flags",     {zero, carry, ovf, neg, illegal}, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      issue(4'd1, 8'h02, 8'h03);
      idle(W + 4);

      rnd_bp = 1'b1;
      for (int i = 0; i < 40; i++)
         issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      rnd_bp = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("drain", 64'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the CPU's 8-bit accumulator ALU.
- Adds configurable WIDTH, a wider opcode set and registered status flags (zero/carry/overflow/negative).
- Adds an iterative multi-cycle multiply and a valid/ready handshake on both input and output.
- Sits between the register/accumulator datapath and the writeback mux; the controller issues operations and stalls on in_ready.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 4..32).
- SHW, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  operation code (see Behaviour).
- a  input  WIDTH  accumulator operand.
- b  input  WIDTH  data operand; low SHW bits give the shift amount.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  registered: result == 0.
- carry  output  1  registered carry/borrow/shifted-out bit/MUL high-half-nonzero.
- ovf  output  1  registered signed overflow (ADD/SUB only, else 0).
- neg  output  1  registered result[WIDTH-1].
- illegal  output  1  registered: op was unassigned.
- acc_zero  output  1  combinational (a == 0), kept for skip-if-zero logic; independent of handshake.

Behaviour:
- Reset (rst_ low, async): state=IDLE; result, zero, carry, ovf, neg, illegal, out_valid = 0; multiply counter and partials cleared. in_ready=1 after reset release.
- Handshake: accept when in_valid && in_ready at posedge. in_ready = (state==IDLE) || (state==HOLD && out_ready). Result held stable while out_valid && !out_ready. Output transfer when out_valid && out_ready.
- States:
  - IDLE: on accept of a single-cycle op -> HOLD; on accept of MUL -> MULB.
  - MULB: runs exactly WIDTH iterations, one per clock, then -> HOLD. in_ready=0 throughout; out_valid=0.
  - HOLD: out_valid=1. If out_ready and a new op is accepted the same cycle -> back-to-back (HOLD for single-cycle, MULB for MUL). If out_ready and no accept -> IDLE.
- Latency: single-cycle op: out_valid on the cycle after the accepting edge. MUL: out_valid WIDTH+1 cycles after the accepting edge. Operands are captured at accept; later changes to a/b are ignored.
- Ops:
  - 0 PASS: result=a.
  - 1 ADD: a+b; carry=bit WIDTH of the sum.
  - 2 SUB: a-b; carry=borrow (a<b unsigned).
  - 3 AND, 4 OR, 5 XOR.
  - 6 LDB: result=b.
  - 7 SHL: carry=last bit shifted out.
  - 8 SHR: logical; carry=last bit out.
  - 9 SAR: arithmetic; carry=last bit out. Shift by 0 gives carry=0.
  - 10 MUL: unsigned shift-add; result=low WIDTH bits; carry=1 if high WIDTH bits are nonzero.
  - 11-15: result=a, illegal=1, all other flags computed from the result with carry=ovf=0.
- Overflow: ADD ovf = (a,b same sign) && result sign differs. SUB ovf = (a,b differ in sign) && result sign differs from a.
- Flags update only when a result is loaded; held otherwise. illegal clears on the next legal result.
- Reset mid-MUL: aborts immediately and returns to the reset state; no partial result is ever presented.
- No internal accumulator; a/b come from the caller each operation.

Test Plan:
- WIDTH=8: ADD a=0xFF b=0x01 -> result 0x00, zero=1, carry=1, ovf=0, out_valid one cycle after accept. ADD a=0x7F b=0x01 -> 0x80, ovf=1, neg=1.
- SUB a=0x00 b=0x01 -> 0xFF, carry=1, neg=1, ovf=0. SUB a=0x80 b=0x01 -> 0x7F, ovf=1.
- MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles; out_valid 9 cycles after accept; result 0x10, carry=1. MUL 0x0F*0x0F -> 0xE1, carry=0.
- Shifts: SHR a=0x81 b=1 -> 0x40, carry=1. SAR a=0x80 b=3 -> 0xF0, carry=0. SHL a=0x01 b=0 -> 0x01, carry=0. op=12 -> result=a, illegal=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result/flags stable, in_ready=0, no new accept. Then out_ready=1 with a pending ADD -> transfer and accept in the same cycle, next result out_valid the following cycle.
- Drive rst_ low asynchronously at MUL iteration 4 -> out_valid, result and flags are 0 immediately. After release, in_ready=1 and a fresh ADD 0x02+0x03 gives 0x05.
